// File: rtl/servant_rst_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : servant_rst_seq_pkg
//  Brief    : State encodings and width helper shared by the reset sequencer,
//             board tops and benches that decode the sequencer state.
//  Revision : 1.0  initial release
// ============================================================================
package servant_rst_seq_pkg;

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4
    } rst_seq_state_t;

    // Counter width for a count range of 'value', never narrower than one bit
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/servant_sync2.sv
`default_nettype none
// ============================================================================
//  Module   : servant_sync2
//  Brief    : Generic two-flop synchroniser, asynchronous active-low reset to 0.
//  Revision : 1.0  initial release
// ============================================================================
module servant_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/servant_rst_seq.sv
`default_nettype none
// ============================================================================
//  Module   : servant_rst_seq
//  Brief    : Board reset sequencer: qualifies PLL lock, then releases NCH
//             active-high reset domains in staggered order. Define
//             SERVANT_RST_SEQ_HEARTBEAT_EN for a heartbeat LED in RUN.
//  Revision : 1.0  initial release
// ============================================================================
module servant_rst_seq
    import servant_rst_seq_pkg::*;
#(
    parameter int NCH           = 3,
    parameter int STABLE_CYCLES = 1024,
    parameter int STAGE_GAP     = 16,
    parameter int HB_BITS       = 24
) (
    input  logic           wb_clk,
    input  logic           wb_rst_n,
    input  logic           i_locked,
    input  logic           i_sw_rst,
    output logic [NCH-1:0] o_rst,
    output logic           o_done,
    output logic           o_led
);

    localparam int c_cnt_w = clog2_min1(STABLE_CYCLES);
    localparam int c_gap_w = clog2_min1(STAGE_GAP);
    localparam int c_idx_w = clog2_min1(NCH);

    localparam logic [c_cnt_w-1:0] c_cnt_last  = c_cnt_w'(STABLE_CYCLES - 1);
    localparam logic [c_gap_w-1:0] c_gap_last  = c_gap_w'(STAGE_GAP - 1);
    localparam logic [c_idx_w-1:0] c_idx_last  = c_idx_w'(NCH - 1);
    localparam logic [c_idx_w-1:0] c_idx_first = c_idx_w'(1);

    logic                 w_lock_s;
    rst_seq_state_t       r_state, w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt, w_cnt_nxt;
    logic [c_gap_w-1:0]   r_gap, w_gap_nxt;
    logic [c_idx_w-1:0]   r_idx, w_idx_nxt;
    logic [NCH-1:0]       r_rst, w_rst_nxt;
    logic                 r_done, w_done_nxt;
    logic [NCH-1:0]       w_rst_shift;

    servant_sync2 #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk   (wb_clk),
        .rst_n (wb_rst_n),
        .i_d   (i_locked),
        .o_q   (w_lock_s)
    );

    // Releasing one more domain shifts a zero in from the bottom, so the
    // release order can never be violated.
    assign w_rst_shift = r_rst << 1;

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_state <= ST_RESET;
            r_cnt   <= '0;
            r_gap   <= '0;
            r_idx   <= '0;
            r_rst   <= '1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gap   <= w_gap_nxt;
            r_idx   <= w_idx_nxt;
            r_rst   <= w_rst_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_gap_nxt   = r_gap;
        w_idx_nxt   = r_idx;
        w_rst_nxt   = r_rst;
        w_done_nxt  = r_done;
        case (r_state)
            ST_RESET: begin
                w_state_nxt = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (w_lock_s) begin
                    w_state_nxt = ST_STABLE;
                    w_cnt_nxt   = '0;
                end
            end
            ST_STABLE: begin
                if (!w_lock_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_cnt_last) begin
                    w_cnt_nxt = '0;
                    w_gap_nxt = '0;
                    w_idx_nxt = c_idx_first;
                    w_rst_nxt = w_rst_shift;
                    if (NCH == 1) begin
                        w_state_nxt = ST_RUN;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_RELEASE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_w'(1);
                end
            end
            ST_RELEASE, ST_RUN: begin
                if (!w_lock_s || i_sw_rst) begin
                    // Lock loss takes priority over a software request
                    w_state_nxt = w_lock_s ? ST_STABLE : ST_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                    w_gap_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_rst_nxt   = '1;
                    w_done_nxt  = 1'b0;
                end else if (r_state == ST_RELEASE) begin
                    if (r_gap == c_gap_last) begin
                        w_gap_nxt = '0;
                        w_rst_nxt = w_rst_shift;
                        if (r_idx == c_idx_last) begin
                            w_state_nxt = ST_RUN;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_idx_nxt = r_idx + c_idx_w'(1);
                        end
                    end else begin
                        w_gap_nxt = r_gap + c_gap_w'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_WAIT_LOCK;
                w_cnt_nxt   = '0;
                w_gap_nxt   = '0;
                w_idx_nxt   = '0;
                w_rst_nxt   = '1;
                w_done_nxt  = 1'b0;
            end
        endcase
    end

    assign o_rst  = r_rst;
    assign o_done = r_done;

`ifdef SERVANT_RST_SEQ_HEARTBEAT_EN
    logic [HB_BITS-1:0] r_hb;

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_hb <= '0;
        end else if (r_state == ST_RUN && w_state_nxt == ST_RUN) begin
            r_hb <= r_hb + HB_BITS'(1);
        end else begin
            r_hb <= '0;
        end
    end

    assign o_led = r_hb[HB_BITS-1];
`else
    assign o_led = r_done;
`endif

endmodule
`default_nettype wire
